// File: rtl/issueq_request_gen_if.sv
// Dispatch / wakeup / grant / flush bundle between the issue queue and its neighbours.
// The master side drives the requests; the issue queue sits on the slave side.
interface issueq_request_gen_if #(
    parameter int ISSUE_DEPTH     = 32,
    parameter int ISSUE_DEPTH_LOG = 5,
    parameter int TAG_WIDTH       = 7
);
    logic                       flush_i;
    logic                       dispatchValid_i;
    logic [TAG_WIDTH-1:0]       dispatchSrc1Tag_i;
    logic                       dispatchSrc1Ready_i;
    logic [TAG_WIDTH-1:0]       dispatchSrc2Tag_i;
    logic                       dispatchSrc2Ready_i;
    logic                       wakeupValid_i;
    logic [TAG_WIDTH-1:0]       wakeupTag_i;
    logic                       grantedValid_i;
    logic [ISSUE_DEPTH_LOG-1:0] grantedEntry_i;
    logic [ISSUE_DEPTH-1:0]     requestVector_o;
    logic [ISSUE_DEPTH_LOG-1:0] freeEntry_o;
    logic                       freeValid_o;
    logic [ISSUE_DEPTH_LOG:0]   freeCount_o;
    logic                       error_o;

    modport master (
        output flush_i, dispatchValid_i, dispatchSrc1Tag_i, dispatchSrc1Ready_i,
               dispatchSrc2Tag_i, dispatchSrc2Ready_i, wakeupValid_i, wakeupTag_i,
               grantedValid_i, grantedEntry_i,
        input  requestVector_o, freeEntry_o, freeValid_o, freeCount_o, error_o
    );

    modport slave (
        input  flush_i, dispatchValid_i, dispatchSrc1Tag_i, dispatchSrc1Ready_i,
               dispatchSrc2Tag_i, dispatchSrc2Ready_i, wakeupValid_i, wakeupTag_i,
               grantedValid_i, grantedEntry_i,
        output requestVector_o, freeEntry_o, freeValid_o, freeCount_o, error_o
    );
endinterface

// File: rtl/issueq_request_gen.sv
// Issue-queue entry tracker: allocates entries on dispatch, marks operands ready on
// wakeup, frees entries on grant and presents the per-entry request vector to select.
module issueq_request_gen #(
    parameter int ISSUE_DEPTH     = 32,
    parameter int ISSUE_DEPTH_LOG = 5,
    parameter int TAG_WIDTH       = 7
) (
    input logic                 clk,
    input logic                 reset,
    issueq_request_gen_if.slave iq
);
    localparam int CNT_W = ISSUE_DEPTH_LOG + 1;

    logic [ISSUE_DEPTH-1:0]     valid_q, valid_d;
    logic [ISSUE_DEPTH-1:0]     src1_rdy_q, src1_rdy_d;
    logic [ISSUE_DEPTH-1:0]     src2_rdy_q, src2_rdy_d;
    logic [TAG_WIDTH-1:0]       src1_tag_q [ISSUE_DEPTH];
    logic [TAG_WIDTH-1:0]       src1_tag_d [ISSUE_DEPTH];
    logic [TAG_WIDTH-1:0]       src2_tag_q [ISSUE_DEPTH];
    logic [TAG_WIDTH-1:0]       src2_tag_d [ISSUE_DEPTH];
    logic [CNT_W-1:0]           free_count_q, free_count_d;
    logic                       error_q, error_d;

    logic [ISSUE_DEPTH-1:0]     request_vec;
    logic [ISSUE_DEPTH_LOG-1:0] free_entry;
    logic                       free_valid;
    logic                       disp_acc;
    logic                       grant_ok;

    assign request_vec = valid_q & src1_rdy_q & src2_rdy_q;

    // Lowest-index free entry; scanning downward lets the lowest match win.
    always_comb begin : free_search
        free_entry = '0;
        free_valid = 1'b0;
        for (int i = ISSUE_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_entry = ISSUE_DEPTH_LOG'(i);
                free_valid = 1'b1;
            end
        end
    end

    assign disp_acc = iq.dispatchValid_i & free_valid;
    assign grant_ok = iq.grantedValid_i & request_vec[iq.grantedEntry_i];

    always_comb begin : next_state
        valid_d      = valid_q;
        src1_rdy_d   = src1_rdy_q;
        src2_rdy_d   = src2_rdy_q;
        src1_tag_d   = src1_tag_q;
        src2_tag_d   = src2_tag_q;
        free_count_d = free_count_q;
        error_d      = 1'b0;

        if (iq.flush_i) begin
            valid_d      = '0;
            src1_rdy_d   = '0;
            src2_rdy_d   = '0;
            free_count_d = CNT_W'(ISSUE_DEPTH);
        end else begin
            for (int i = 0; i < ISSUE_DEPTH; i++) begin
                if (iq.wakeupValid_i && valid_q[i]) begin
                    if (src1_tag_q[i] == iq.wakeupTag_i) src1_rdy_d[i] = 1'b1;
                    if (src2_tag_q[i] == iq.wakeupTag_i) src2_rdy_d[i] = 1'b1;
                end
            end

            if (grant_ok) valid_d[iq.grantedEntry_i] = 1'b0;

            // free_entry is always an invalid entry, so it never collides with the grant.
            if (disp_acc) begin
                valid_d[free_entry]    = 1'b1;
                src1_tag_d[free_entry] = iq.dispatchSrc1Tag_i;
                src2_tag_d[free_entry] = iq.dispatchSrc2Tag_i;
                src1_rdy_d[free_entry] = iq.dispatchSrc1Ready_i |
                    (iq.wakeupValid_i & (iq.wakeupTag_i == iq.dispatchSrc1Tag_i));
                src2_rdy_d[free_entry] = iq.dispatchSrc2Ready_i |
                    (iq.wakeupValid_i & (iq.wakeupTag_i == iq.dispatchSrc2Tag_i));
            end

            free_count_d = free_count_q - CNT_W'(disp_acc) + CNT_W'(grant_ok);
            error_d      = (iq.dispatchValid_i & ~free_valid) |
                           (iq.grantedValid_i & ~grant_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q      <= '0;
            src1_rdy_q   <= '0;
            src2_rdy_q   <= '0;
            free_count_q <= CNT_W'(ISSUE_DEPTH);
            error_q      <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            src1_rdy_q   <= src1_rdy_d;
            src2_rdy_q   <= src2_rdy_d;
            free_count_q <= free_count_d;
            error_q      <= error_d;
        end
    end

    // Tags are only meaningful while the entry is valid, so they carry no reset.
    always_ff @(posedge clk) begin
        src1_tag_q <= src1_tag_d;
        src2_tag_q <= src2_tag_d;
    end

    assign iq.requestVector_o = request_vec;
    assign iq.freeEntry_o     = free_entry;
    assign iq.freeValid_o     = free_valid;
    assign iq.freeCount_o     = free_count_q;
    assign iq.error_o         = error_q;
endmodule

// File: doc/issueq_request_gen.md
Name: issueq_request_gen

Overview:
- Issue-queue side counterpart of the select tree: it owns per-entry valid/operand-ready state and produces the request vector that select consumes.
- Consumes select's grant (valid + encoded entry) and frees the granted entry.
- Supplies the lowest free entry index to dispatch and tracks wakeup broadcasts.
- One dispatch, one wakeup, one grant per cycle.

Parameters:
ISSUE_DEPTH, 32, number of issue-queue entries (power of 2, ≥4)
ISSUE_DEPTH_LOG, 5, log2(ISSUE_DEPTH)
TAG_WIDTH, 7, physical register tag width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
flush_i  in  1  clear all entries (pipeline flush)
dispatchValid_i  in  1  write new instruction into freeEntry_o this cycle
dispatchSrc1Tag_i  in  TAG_WIDTH  source 1 tag
dispatchSrc1Ready_i  in  1  source 1 already ready
dispatchSrc2Tag_i  in  TAG_WIDTH  source 2 tag
dispatchSrc2Ready_i  in  1  source 2 already ready
wakeupValid_i  in  1  tag broadcast valid
wakeupTag_i  in  TAG_WIDTH  broadcast tag
grantedValid_i  in  1  select granted an entry
grantedEntry_i  in  ISSUE_DEPTH_LOG  granted entry index
requestVector_o  out  ISSUE_DEPTH  per-entry request to select
freeEntry_o  out  ISSUE_DEPTH_LOG  lowest-index free entry
freeValid_o  out  1  at least one free entry (not full)
freeCount_o  out  ISSUE_DEPTH_LOG+1  number of free entries (registered)
error_o  out  1  one-cycle pulse on protocol violation

Behaviour:
- Per-entry state: valid, src1Rdy, src2Rdy, src1Tag, src2Tag.
- requestVector_o[i] = valid[i] & src1Rdy[i] & src2Rdy[i].
  - Purely from registered state; no combinational path from any input.
- freeEntry_o is the lowest index with valid=0, from registered state.
  - When full: freeEntry_o=0 and freeValid_o=0.
- Reset (reset=0 at edge):
  - All valid/rdy bits cleared; freeCount_o=ISSUE_DEPTH; error_o=0.
  - requestVector_o=0, freeValid_o=1, freeEntry_o=0.
  - Reset overrides every other input in the same cycle, including mid-dispatch or mid-grant.
- Flush (flush_i=1, reset=1): same clearing effect as reset.
  - Dispatch, wakeup and grant in the same cycle are ignored.
  - No error pulse.
- Dispatch accepted when dispatchValid_i & freeValid_o. At the edge, entry freeEntry_o is updated:
  - valid←1; tags written.
  - srcNRdy ← dispatchSrcNReady_i | (wakeupValid_i & wakeupTag_i==dispatchSrcNTag_i). This is the same-cycle wakeup bypass.
- Dispatch with freeValid_o=0: dropped; error_o=1 next cycle.
- Wakeup: for every valid entry with a matching tag, that source's rdy←1 at the edge.
  - Both sources may match in one cycle.
  - A non-matching broadcast has no effect.
- Grant (grantedValid_i=1):
  - If the entry is valid, valid←0 at the edge.
  - If the entry is invalid or not requesting: no state change; error_o=1 next cycle.
- Latency: dispatch-ready, wakeup and grant each change requestVector_o and freeEntry_o/freeValid_o exactly one cycle later.
- Same-cycle dispatch and grant:
  - freeEntry_o is computed before the grant, so the granted entry is never reallocated in the same cycle.
  - Both updates apply.
  - freeCount_o is unchanged (−1 +1).
- freeCount_o next value = freeCount − accepted dispatch + valid grant.
  - Saturation is never reached under legal use.
- error_o is a single-cycle pulse, not sticky.

Test Plan:
- Reset with ISSUE_DEPTH=8, then dispatch 3 instructions with both sources ready on consecutive cycles → entries 0,1,2 allocated; requestVector_o=8'b0000_0111 one cycle after the third dispatch; freeCount_o=5; freeEntry_o=3.
- Dispatch src1Tag=5 not ready, src2 ready; broadcast tag 5 two cycles later → request bit low until the cycle after the wakeup, then high. Repeat with the wakeup of tag 5 in the same cycle as dispatch → request high the very next cycle (bypass).
- Fill all 8 entries → freeValid_o=0, freeCount_o=0. A 9th dispatch → dropped, error_o pulses 1 cycle, state unchanged. Grant entry 4 → next cycle freeValid_o=1, freeEntry_o=4.
- Same cycle: grant entry 2 and dispatch with entries 0–2 full → new instruction lands in entry 3, entry 2 frees; next cycle freeEntry_o=2, freeCount_o unchanged.
- Grant an invalid entry 6 → error_o pulses, no state change. Assert flush_i with 5 entries valid → next cycle requestVector_o=0, freeCount_o=8, no error.
- Drive reset=0 in the same cycle as dispatch, wakeup and grant → all dropped; outputs at reset values the next cycle. Deasserting reset resumes normal allocation from entry 0.
